// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and edge-detect active-low push-buttons.
// One key_chan instance per key; channels share nothing but clk/reset_n.
//
// Ports (all vectors are N_KEYS wide, bit i belongs to key i):
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   key_n        raw asynchronous buttons, 0 = pressed
//   event_clr    clears the sticky flags (pulse or level)
//   key_level    debounced state, 1 = pressed
//   key_press    1-cycle pulse on an accepted press
//   key_release  1-cycle pulse on an accepted release
//   key_long     1-cycle pulse once per press after HOLD_CYCLES of press
//   press_sticky set by key_press, held until event_clr
//   long_sticky  set by key_long, held until event_clr

// key_chan: one key's synchroniser, debounce FSM, hold timer and sticky flags.
//   key_n/event_clr in, lvl/prs/rls/lng/prs_stk/lng_stk out (all registered).
module key_chan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic event_clr,
  output logic lvl,
  output logic prs,
  output logic rls,
  output logic lng,
  output logic prs_stk,
  output logic lng_stk
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} st_t;

  st_t           st, st_nxt;
  logic [1:0]    sync;
  logic          s;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          lvl_nxt, prs_nxt, rls_nxt, lng_nxt;

  assign s = sync[1];

  always_comb begin
    st_nxt   = st;
    dcnt_nxt = dcnt;
    hcnt_nxt = hcnt;
    lvl_nxt  = lvl;
    prs_nxt  = 1'b0;
    rls_nxt  = 1'b0;
    lng_nxt  = 1'b0;
    // Hold timer runs through RELEASE_WAIT too, so a long press that
    // matures while the release is still being debounced is reported.
    // Saturating at HOLD_CYCLES makes key_long fire only once per press.
    if ((st == PRESSED || st == RELEASE_WAIT) && hcnt != H_SAT) begin
      hcnt_nxt = hcnt + HW'(1);
      lng_nxt  = (hcnt == H_LAST);
    end
    case (st)
      IDLE: begin
        if (s) begin
          st_nxt   = PRESS_WAIT;
          dcnt_nxt = D_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          st_nxt   = IDLE;
          dcnt_nxt = '0;
        end else if (dcnt == D_LAST) begin
          st_nxt   = PRESSED;
          dcnt_nxt = '0;
          hcnt_nxt = '0;
          lvl_nxt  = 1'b1;
          prs_nxt  = 1'b1;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          st_nxt   = RELEASE_WAIT;
          dcnt_nxt = D_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          st_nxt   = PRESSED;
          dcnt_nxt = '0;
        end else if (dcnt == D_LAST) begin
          st_nxt   = IDLE;
          dcnt_nxt = '0;
          lvl_nxt  = 1'b0;
          rls_nxt  = 1'b1;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= '0;
      st      <= IDLE;
      dcnt    <= '0;
      hcnt    <= '0;
      lvl     <= 1'b0;
      prs     <= 1'b0;
      rls     <= 1'b0;
      lng     <= 1'b0;
      prs_stk <= 1'b0;
      lng_stk <= 1'b0;
    end else begin
      sync    <= {sync[0], ~key_n};
      st      <= st_nxt;
      dcnt    <= dcnt_nxt;
      hcnt    <= hcnt_nxt;
      lvl     <= lvl_nxt;
      prs     <= prs_nxt;
      rls     <= rls_nxt;
      lng     <= lng_nxt;
      // Set beats clear when both land in the same cycle.
      prs_stk <= prs | (prs_stk & ~event_clr);
      lng_stk <= lng | (lng_stk & ~event_clr);
    end
  end
endmodule

module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_KEYS-1:0] event_clr,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] press_sticky,
  output logic [N_KEYS-1:0] long_sticky
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_n    (key_n[i]),
      .event_clr(event_clr[i]),
      .lvl      (key_level[i]),
      .prs      (key_press[i]),
      .rls      (key_release[i]),
      .lng      (key_long[i]),
      .prs_stk  (press_sticky[i]),
      .lng_stk  (long_sticky[i])
    );
  end
endmodule
